// File: rtl/boundary_cfg_ctrl.sv
// Corner-point configuration sequencer: collects TL/TR/BL/BR, validates the bounding box,
// and commits it to the draw registers only at a fixed blanking raster position.
// Optional macro BOUNDARY_CFG_ERRCNT_EN adds a saturating 8-bit err_count output.
module boundary_cfg_ctrl #(
  parameter int p_screen_width  = 640,
  parameter int p_screen_height = 480,
  parameter int p_max_span      = 255,
  parameter int p_commit_line   = 480,
  parameter int p_timeout       = 1024,
  parameter int p_def_sx        = 100,
  parameter int p_def_sy        = 100,
  parameter int p_def_ex        = 180,
  parameter int p_def_ey        = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        corner_valid,
  output logic        corner_ready,
  input  logic [1:0]  corner_idx,
  input  logic [10:0] corner_x,
  input  logic [10:0] corner_y,
  input  logic [10:0] VGA_X,
  input  logic [10:0] VGA_Y,
  output logic [10:0] draw_start_x,
  output logic [10:0] draw_start_y,
  output logic [10:0] draw_end_x,
  output logic [10:0] draw_end_y,
  output logic        cfg_valid,
  output logic        commit_pulse,
  output logic        err_pulse
`ifdef BOUNDARY_CFG_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int tmo_w_c = $clog2(p_timeout);
  localparam logic [tmo_w_c-1:0] tmo_last_c = tmo_w_c'(p_timeout - 1);
  localparam logic [10:0] scr_w_c   = 11'(p_screen_width);
  localparam logic [10:0] scr_h_c   = 11'(p_screen_height);
  localparam logic [10:0] span_c    = 11'(p_max_span);
  localparam logic [10:0] commit_y_c = 11'(p_commit_line);

  // Bit 1 of the encoding marks the busy states, so ready is a plain register bit.
  typedef enum logic [1:0] {
    st_idle    = 2'b00,
    st_collect = 2'b01,
    st_check   = 2'b10,
    st_pending = 2'b11
  } state_t;

  state_t             state_r;
  logic [1:0]         exp_idx_r;
  logic [tmo_w_c-1:0] tmo_cnt_r;
  logic [10:0]        pt_x_r [4];
  logic [10:0]        pt_y_r [4];
  logic [10:0]        cand_sx_r, cand_sy_r, cand_ex_r, cand_ey_r;
  logic [10:0]        box_sx_s, box_sy_s, box_ex_s, box_ey_s;
  logic               box_ok_s;
  logic               accept_s;
  logic               commit_hit_s;

  assign corner_ready = ~state_r[1];
  assign accept_s     = corner_valid & corner_ready;
  assign commit_hit_s = (VGA_X == 11'd0) && (VGA_Y == commit_y_c);

  // Candidate bounding box and its validity, from the stored corners.
  always_comb begin
    box_sx_s = (pt_x_r[0] < pt_x_r[2]) ? pt_x_r[0] : pt_x_r[2];
    box_sy_s = (pt_y_r[0] < pt_y_r[1]) ? pt_y_r[0] : pt_y_r[1];
    box_ex_s = (pt_x_r[1] > pt_x_r[3]) ? pt_x_r[1] : pt_x_r[3];
    box_ey_s = (pt_y_r[2] > pt_y_r[3]) ? pt_y_r[2] : pt_y_r[3];
    box_ok_s = 1'b0;
    // Spans are only evaluated once ordering holds, so the subtraction cannot wrap.
    if ((box_ex_s > box_sx_s) && (box_ey_s > box_sy_s)) begin
      box_ok_s = (box_ex_s < scr_w_c) && (box_ey_s < scr_h_c) &&
                 ((box_ex_s - box_sx_s) <= span_c) && ((box_ey_s - box_sy_s) <= span_c);
    end else begin
      box_ok_s = 1'b0;
    end
  end

  // Sequencer FSM with corner storage, candidate box and committed outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= st_idle;
      exp_idx_r    <= 2'd0;
      tmo_cnt_r    <= '0;
      pt_x_r       <= '{default: 11'd0};
      pt_y_r       <= '{default: 11'd0};
      cand_sx_r    <= 11'd0;
      cand_sy_r    <= 11'd0;
      cand_ex_r    <= 11'd0;
      cand_ey_r    <= 11'd0;
      draw_start_x <= 11'(p_def_sx);
      draw_start_y <= 11'(p_def_sy);
      draw_end_x   <= 11'(p_def_ex);
      draw_end_y   <= 11'(p_def_ey);
      cfg_valid    <= 1'b0;
      commit_pulse <= 1'b0;
      err_pulse    <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      err_pulse    <= 1'b0;
      case (state_r)
        st_idle: begin
          if (accept_s) begin
            if (corner_idx == 2'd0) begin
              pt_x_r[0] <= corner_x;
              pt_y_r[0] <= corner_y;
              exp_idx_r <= 2'd1;
              tmo_cnt_r <= '0;
              state_r   <= st_collect;
            end else begin
              err_pulse <= 1'b1;
            end
          end
        end
        st_collect: begin
          if (accept_s) begin
            tmo_cnt_r <= '0;
            if (corner_idx == exp_idx_r) begin
              pt_x_r[corner_idx] <= corner_x;
              pt_y_r[corner_idx] <= corner_y;
              exp_idx_r <= exp_idx_r + 2'd1;
              if (corner_idx == 2'd3) begin
                state_r <= st_check;
              end
            end else if (corner_idx == 2'd0) begin
              // Out-of-order TL restarts the set rather than wasting the corner.
              err_pulse <= 1'b1;
              pt_x_r[0] <= corner_x;
              pt_y_r[0] <= corner_y;
              exp_idx_r <= 2'd1;
            end else begin
              err_pulse <= 1'b1;
              exp_idx_r <= 2'd0;
              state_r   <= st_idle;
            end
          end else if (tmo_cnt_r == tmo_last_c) begin
            err_pulse <= 1'b1;
            exp_idx_r <= 2'd0;
            tmo_cnt_r <= '0;
            state_r   <= st_idle;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
          end
        end
        st_check: begin
          exp_idx_r <= 2'd0;
          if (box_ok_s) begin
            cand_sx_r <= box_sx_s;
            cand_sy_r <= box_sy_s;
            cand_ex_r <= box_ex_s;
            cand_ey_r <= box_ey_s;
            state_r   <= st_pending;
          end else begin
            err_pulse <= 1'b1;
            state_r   <= st_idle;
          end
        end
        st_pending: begin
          if (commit_hit_s) begin
            draw_start_x <= cand_sx_r;
            draw_start_y <= cand_sy_r;
            draw_end_x   <= cand_ex_r;
            draw_end_y   <= cand_ey_r;
            commit_pulse <= 1'b1;
            cfg_valid    <= 1'b1;
            state_r      <= st_idle;
          end
        end
        default: begin
          state_r <= st_idle;
        end
      endcase
    end
  end

`ifdef BOUNDARY_CFG_ERRCNT_EN
  // Saturating error counter, cleared by a commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= 8'd0;
    end else if (commit_pulse) begin
      err_count <= 8'd0;
    end else if (err_pulse && (err_count != 8'd255)) begin
      err_count <= err_count + 8'd1;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_boundary_cfg_ctrl.sv
// Self-checking bench for boundary_cfg_ctrl: directed scenarios plus randomized corner
// streams, compared every cycle against a set-level behavioural model.
module tb_boundary_cfg_ctrl;

  localparam int P_TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        corner_valid = 1'b0;
  logic        corner_ready;
  logic [1:0]  corner_idx = 2'd0;
  logic [10:0] corner_x = 11'd0, corner_y = 11'd0;
  logic [10:0] VGA_X = 11'd1, VGA_Y = 11'd1;
  logic [10:0] draw_start_x, draw_start_y, draw_end_x, draw_end_y;
  logic        cfg_valid, commit_pulse, err_pulse;
`ifdef BOUNDARY_CFG_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  boundary_cfg_ctrl dut (
    .clk(clk), .reset(reset),
    .corner_valid(corner_valid), .corner_ready(corner_ready),
    .corner_idx(corner_idx), .corner_x(corner_x), .corner_y(corner_y),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y),
    .draw_start_x(draw_start_x), .draw_start_y(draw_start_y),
    .draw_end_x(draw_end_x), .draw_end_y(draw_end_y),
    .cfg_valid(cfg_valid), .commit_pulse(commit_pulse), .err_pulse(err_pulse)
`ifdef BOUNDARY_CFG_ERRCNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: set progress as a corner count, plus check/pending flags.
  int m_got, m_quiet, m_errcnt;
  bit m_check, m_pend, m_cfg, m_commit, m_err;
  int m_px[4], m_py[4], m_cand[4], m_draw[4];

  function automatic bit m_ready();
    return !(m_check || m_pend);
  endfunction

  task automatic model_reset();
    m_got = 0; m_quiet = 0; m_errcnt = 0;
    m_check = 0; m_pend = 0; m_cfg = 0; m_commit = 0; m_err = 0;
    m_draw = '{100, 100, 180, 200};
  endtask

  task automatic model_eval();
    bit acc;
    int i, sx, sy, ex, ey;
    acc = corner_valid && m_ready();
    i = int'(corner_idx);
    if (m_commit) m_errcnt = 0;
    else if (m_err && m_errcnt < 255) m_errcnt++;
    m_commit = 0; m_err = 0;
    if (m_pend) begin
      if (VGA_X == 0 && VGA_Y == 480) begin
        m_draw = m_cand; m_commit = 1; m_cfg = 1; m_pend = 0;
      end
    end else if (m_check) begin
      m_check = 0;
      sx = (m_px[0] < m_px[2]) ? m_px[0] : m_px[2];
      sy = (m_py[0] < m_py[1]) ? m_py[0] : m_py[1];
      ex = (m_px[1] > m_px[3]) ? m_px[1] : m_px[3];
      ey = (m_py[2] > m_py[3]) ? m_py[2] : m_py[3];
      if (ex > sx && ey > sy && ex < 640 && ey < 480 && ex - sx <= 255 && ey - sy <= 255) begin
        m_cand = '{sx, sy, ex, ey}; m_pend = 1;
      end else m_err = 1;
    end else if (acc) begin
      m_quiet = 0;
      if (i == m_got) begin
        m_px[i] = int'(corner_x); m_py[i] = int'(corner_y); m_got++;
        if (m_got == 4) begin m_got = 0; m_check = 1; end
      end else begin
        m_err = 1;
        if (i == 0) begin m_px[0] = int'(corner_x); m_py[0] = int'(corner_y); m_got = 1; end
        else m_got = 0;
      end
    end else if (m_got > 0) begin
      if (m_quiet == P_TIMEOUT - 1) begin m_err = 1; m_got = 0; m_quiet = 0; end
      else m_quiet++;
    end
  endtask

  task automatic compare_all();
    chk("ready", corner_ready, m_ready());
    chk("start_x", draw_start_x, m_draw[0]);
    chk("start_y", draw_start_y, m_draw[1]);
    chk("end_x", draw_end_x, m_draw[2]);
    chk("end_y", draw_end_y, m_draw[3]);
    chk("cfg_valid", cfg_valid, m_cfg);
    chk("commit_pulse", commit_pulse, m_commit);
    chk("err_pulse", err_pulse, m_err);
`ifdef BOUNDARY_CFG_ERRCNT_EN
    chk("err_count", err_count, (m_commit) ? m_errcnt : m_errcnt);
`endif
  endtask

  task automatic step();
    model_eval();
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic send(input int idx, input int x, input int y);
    corner_valid = 1'b1; corner_idx = 2'(idx); corner_x = 11'(x); corner_y = 11'(y);
    step();
    corner_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    corner_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic raster_hit();
    VGA_X = 11'd0; VGA_Y = 11'd480;
    step();
    VGA_X = 11'd1; VGA_Y = 11'd1;
  endtask

  task automatic send_set(input int x0, input int y0, input int x1, input int y1,
                          input int x2, input int y2, input int x3, input int y3);
    send(0, x0, y0); send(1, x1, y1); send(2, x2, y2); send(3, x3, y3);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int bx, by, bw, bh;
  int sxv[4], syv[4];

  initial begin
    model_reset();
    VGA_X = 11'd1; VGA_Y = 11'd1;
    #12;
    chk("rst_start_x", draw_start_x, 100);
    chk("rst_start_y", draw_start_y, 100);
    chk("rst_end_x", draw_end_x, 180);
    chk("rst_end_y", draw_end_y, 200);
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_ready", corner_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // Nominal set: outputs hold until the commit raster point.
    send_set(50, 60, 150, 62, 48, 140, 152, 138);
    idle(5);
    chk("hold_start_x", draw_start_x, 100);
    chk("hold_ready", corner_ready, 0);
    raster_hit();
    chk("tp_commit", commit_pulse, 1);
    chk("tp_sx", draw_start_x, 48);
    chk("tp_sy", draw_start_y, 60);
    chk("tp_ex", draw_end_x, 152);
    chk("tp_ey", draw_end_y, 140);
    chk("tp_cfg", cfg_valid, 1);
    idle(1);
    chk("tp_commit_once", commit_pulse, 0);

    // Out-of-order index, then a clean set.
    send(0, 20, 20);
    send(2, 20, 90);
    chk("ooo_err", err_pulse, 1);
    chk("ooo_ready", corner_ready, 1);
    send_set(20, 20, 90, 22, 21, 90, 91, 91);
    idle(2);
    raster_hit();
    chk("ooo_recommit", commit_pulse, 1);
    chk("ooo_ex", draw_end_x, 91);

    // Timeout after TL, then a stray idx 1 in IDLE.
    send(0, 30, 30);
    idle(P_TIMEOUT - 1);
    chk("tmo_early", err_pulse, 0);
    idle(1);
    chk("tmo_err", err_pulse, 1);
    send(1, 40, 40);
    chk("stray_err", err_pulse, 1);

    // Over-span box is rejected in CHECK and never committed.
    send_set(10, 60, 310, 62, 12, 140, 300, 138);
    idle(1);
    chk("span_err", err_pulse, 1);
    raster_hit();
    chk("span_no_commit", commit_pulse, 0);
    chk("span_hold_ex", draw_end_x, 91);

    // Commit condition seen during CHECK must wait for the next one in PENDING.
    send_set(100, 100, 200, 100, 100, 200, 200, 200);
    raster_hit();
    chk("chk_skip", commit_pulse, 0);
    idle(3);
    raster_hit();
    chk("chk_late_commit", commit_pulse, 1);

    // Reset while pending drops the set and restores defaults.
    send_set(5, 5, 60, 5, 5, 60, 60, 60);
    idle(1);
    reset = 1'b0;
    #2;
    chk("rstp_start_x", draw_start_x, 100);
    chk("rstp_end_y", draw_end_y, 200);
    chk("rstp_cfg", cfg_valid, 0);
    chk("rstp_commit", commit_pulse, 0);
    do_reset();
    idle(2);
    raster_hit();
    chk("rstp_no_commit", commit_pulse, 0);

`ifdef BOUNDARY_CFG_ERRCNT_EN
    send(1, 1, 1); send(2, 1, 1); send(3, 1, 1);
    idle(1);
    chk("errcnt_3", err_count, 3);
    send_set(50, 60, 150, 62, 48, 140, 152, 138);
    idle(2);
    raster_hit();
    idle(1);
    chk("errcnt_clr", err_count, 0);
`endif

    // Randomized corner streams and raster positions.
    for (int n = 0; n < 4000; n++) begin
      if (m_got == 0) begin
        bx = $urandom_range(0, 700); by = $urandom_range(0, 520);
        bw = $urandom_range(0, 300); bh = $urandom_range(0, 300);
        sxv = '{bx + $urandom_range(0, 4), bx + bw + $urandom_range(0, 4),
                bx + $urandom_range(0, 4), bx + bw + $urandom_range(0, 4)};
        syv = '{by + $urandom_range(0, 4), by + $urandom_range(0, 4),
                by + bh + $urandom_range(0, 4), by + bh + $urandom_range(0, 4)};
      end
      corner_valid = ($urandom_range(0, 3) != 0);
      corner_idx = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'(m_got);
      corner_x = 11'(sxv[corner_idx]);
      corner_y = 11'(syv[corner_idx]);
      if ($urandom_range(0, 3) == 0) begin
        VGA_X = 11'd0; VGA_Y = 11'd480;
      end else begin
        VGA_X = 11'($urandom_range(0, 799)); VGA_Y = 11'($urandom_range(0, 524));
      end
      step();
    end
    corner_valid = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
